// File: rtl/traceback_block.sv
// Block-mode Viterbi traceback: every L new survivor columns, trace D+L columns back and emit L bits oldest first.
// Optional sticky overrun flag and request-drop behaviour are enabled by defining TB_OVERRUN_EN.
module traceback_block #(
    parameter int K     = 7,
    parameter int M     = K - 1,
    parameter int D     = 40,
    parameter int L     = 8,
    parameter int DEPTH = D + L,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          col_valid,
    input  logic [AW-1:0] wr_ptr,
    input  logic [M-1:0]  s_end,
    input  logic          force_state0,
    output logic [AW-1:0] tb_time,
    output logic [M-1:0]  tb_state,
    input  logic          tb_surv_bit,
    output logic          dec_valid,
    input  logic          dec_ready,
    output logic          dec_bit,
    output logic          busy
`ifdef TB_OVERRUN_EN
    ,
    output logic          overrun
`endif
);

    localparam int FW = $clog2(DEPTH + 1);
    localparam int NW = $clog2(L + 1);
    localparam int SW = $clog2(D + L + 1);
    localparam int CW = $clog2(L + 1);

    typedef enum logic [2:0] {IDLE, PRIME, TRACE, DECODE, OUT} state_t;

    state_t        state_q, state_d;
    logic [FW-1:0] fill_q, fill_d;
    logic [NW-1:0] newcols_q, newcols_d;
    logic          pending_q, pending_d;
    logic [M-1:0]  st_q, st_d;
    logic [AW-1:0] tb_time_q, tb_time_d;
    logic [M-1:0]  tb_state_q, tb_state_d;
    logic [SW-1:0] step_q, step_d;
    logic [L-1:0]  lifo_q, lifo_d;
    logic [CW-1:0] lifo_cnt_q, lifo_cnt_d;
    logic          dec_valid_q, dec_valid_d;
    logic          dec_bit_q, dec_bit_d;

    logic          col_req;
    logic          start;
    logic [M-1:0]  pred;
    logic [M-1:0]  st_init;
    logic [AW-1:0] start_col;
    logic [L-1:0]  lifo_push;
    logic [L-1:0]  lifo_pop;

    function automatic logic [AW-1:0] col_dec(input logic [AW-1:0] c);
        return (c == '0) ? AW'(DEPTH - 1) : c - 1'b1;
    endfunction

    assign pred    = {tb_surv_bit, st_q[M-1:1]};
    assign st_init = force_state0 ? '0 : s_end;
    // A column arriving in the start cycle belongs to the next block, so back out its pointer advance.
    assign start_col = col_dec(col_valid ? col_dec(wr_ptr) : wr_ptr);
    assign start     = (state_q == IDLE) && pending_q;

    // Bit 0 is the LIFO top: pushes shift up, pops shift down.
    genvar gi;
    generate
        for (gi = 0; gi < L; gi++) begin : g_lifo
            if (gi == 0) begin : g_bottom
                assign lifo_push[gi] = st_q[0];
            end else begin : g_shift_up
                assign lifo_push[gi] = lifo_q[gi-1];
            end
            if (gi == L - 1) begin : g_top
                assign lifo_pop[gi] = 1'b0;
            end else begin : g_shift_down
                assign lifo_pop[gi] = lifo_q[gi+1];
            end
        end
    endgenerate

    always_comb begin
        fill_d    = fill_q;
        newcols_d = newcols_q;
        col_req   = 1'b0;
        if (col_valid) begin
            if (fill_q < FW'(DEPTH)) fill_d = fill_q + 1'b1;
            if (newcols_q == NW'(L - 1)) begin
                newcols_d = '0;
                col_req   = (fill_d == FW'(DEPTH));
            end else begin
                newcols_d = newcols_q + 1'b1;
            end
        end
        pending_d = col_req | (pending_q & ~start);
    end

    always_comb begin
        state_d     = state_q;
        st_d        = st_q;
        tb_time_d   = tb_time_q;
        tb_state_d  = tb_state_q;
        step_d      = step_q;
        lifo_d      = lifo_q;
        lifo_cnt_d  = lifo_cnt_q;
        dec_valid_d = dec_valid_q;
        dec_bit_d   = dec_bit_q;
        case (state_q)
            IDLE: begin
                if (pending_q) begin
                    st_d       = st_init;
                    tb_state_d = st_init;
                    tb_time_d  = start_col;
                    step_d     = '0;
                    state_d    = PRIME;
                end
            end
            PRIME: state_d = TRACE;
            TRACE, DECODE: begin
                st_d       = pred;
                tb_state_d = pred;
                tb_time_d  = col_dec(tb_time_q);
                step_d     = step_q + 1'b1;
                if (state_q == DECODE) begin
                    lifo_d     = lifo_push;
                    lifo_cnt_d = lifo_cnt_q + 1'b1;
                    if (step_q == SW'(D + L - 1)) state_d = OUT;
                end else if (step_q == SW'(D - 1)) begin
                    state_d = DECODE;
                end
            end
            OUT: begin
                // The output register only advances when empty or when the current beat is taken.
                if (!dec_valid_q || dec_ready) begin
                    if (lifo_cnt_q != '0) begin
                        dec_valid_d = 1'b1;
                        dec_bit_d   = lifo_q[0];
                        lifo_d      = lifo_pop;
                        lifo_cnt_d  = lifo_cnt_q - 1'b1;
                    end else begin
                        dec_valid_d = 1'b0;
                        dec_bit_d   = 1'b0;
                        state_d     = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            fill_q      <= '0;
            newcols_q   <= '0;
            pending_q   <= 1'b0;
            st_q        <= '0;
            tb_time_q   <= '0;
            tb_state_q  <= '0;
            step_q      <= '0;
            lifo_q      <= '0;
            lifo_cnt_q  <= '0;
            dec_valid_q <= 1'b0;
            dec_bit_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            fill_q      <= fill_d;
            newcols_q   <= newcols_d;
            pending_q   <= pending_d;
            st_q        <= st_d;
            tb_time_q   <= tb_time_d;
            tb_state_q  <= tb_state_d;
            step_q      <= step_d;
            lifo_q      <= lifo_d;
            lifo_cnt_q  <= lifo_cnt_d;
            dec_valid_q <= dec_valid_d;
            dec_bit_q   <= dec_bit_d;
        end
    end

`ifdef TB_OVERRUN_EN
    logic overrun_q, overrun_d;

    // A block completing while an unserved one is still queued means the writer lapped the window.
    assign overrun_d = overrun_q | (col_req & pending_q & ~start);

    always_ff @(posedge clk) begin
        if (rst) overrun_q <= 1'b0;
        else     overrun_q <= overrun_d;
    end

    assign overrun = overrun_q;
`endif

    assign tb_time   = tb_time_q;
    assign tb_state  = tb_state_q;
    assign dec_valid = dec_valid_q;
    assign dec_bit   = dec_bit_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_traceback_block.sv
// Bench for traceback_block (K=7, D=40, L=8): table of traceback blocks plus reset and overrun sequences.
// Expected decoded bits are queued when a block is set up and popped on every accepted output beat.
module tb_traceback_block;

    localparam int DEPTH = 48;

    logic       clk = 1'b0;
    logic       rst;
    logic       col_valid;
    logic [5:0] wr_ptr;
    logic [5:0] s_end;
    logic       force_state0;
    logic [5:0] tb_time;
    logic [5:0] tb_state;
    logic       tb_surv_bit;
    logic       dec_valid;
    logic       dec_ready;
    logic       dec_bit;
    logic       busy;
`ifdef TB_OVERRUN_EN
    logic       overrun;
`endif

    logic surv_mem [DEPTH][64];

    always #5 clk = ~clk;

    assign tb_surv_bit = surv_mem[tb_time][tb_state];

    traceback_block dut (
        .clk          (clk),
        .rst          (rst),
        .col_valid    (col_valid),
        .wr_ptr       (wr_ptr),
        .s_end        (s_end),
        .force_state0 (force_state0),
        .tb_time      (tb_time),
        .tb_state     (tb_state),
        .tb_surv_bit  (tb_surv_bit),
        .dec_valid    (dec_valid),
        .dec_ready    (dec_ready),
        .dec_bit      (dec_bit),
        .busy         (busy)
`ifdef TB_OVERRUN_EN
        ,
        .overrun      (overrun)
`endif
    );

    typedef enum int {M_ZERO, M_ONE, M_PATH} mode_t;
    typedef struct {
        mode_t      mode;
        logic       force0;
        logic [5:0] s_end;
        logic [7:0] pat;
        int         stall_at;
        int         stall_len;
        logic [7:0] exp_bits;
    } vec_t;

    vec_t vecs [7];
    int   n_cmp = 0;
    int   n_err = 0;
    int   beats = 0;
    int   wp    = 0;
    logic exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        col_valid    = 1'b0;
        dec_ready    = 1'b1;
        force_state0 = 1'b0;
        s_end        = '0;
        wr_ptr       = '0;
        wp           = 0;
        exp_q.delete();
        repeat (2) tick();
        rst   = 1'b0;
        beats = 0;
    endtask

    task automatic fill_const(input logic b);
        for (int c = 0; c < DEPTH; c++)
            for (int x = 0; x < 64; x++) surv_mem[c][x] = b;
    endtask

    // Forward encoder: survivor of the true state at column c is the bit shifted out of the prior state.
    task automatic encode_path(input logic [7:0] pat, output logic [5:0] s_last);
        logic [5:0] s;
        logic [5:0] prev;
        logic       u;
        s = '0;
        for (int c = 0; c < DEPTH; c++) begin
            for (int x = 0; x < 64; x++) surv_mem[c][x] = 1'($urandom_range(0, 1));
            u    = (c < 8) ? pat[7-c] : 1'($urandom_range(0, 1));
            prev = s;
            s    = {s[4:0], u};
            surv_mem[c][s] = prev[5];
        end
        s_last = s;
    endtask

    task automatic send_cols(input int n);
        for (int i = 0; i < n; i++) begin
            col_valid = 1'b1;
            wp        = (wp + 1) % DEPTH;
            wr_ptr    = 6'(wp);
            tick();
        end
        col_valid = 1'b0;
    endtask

    task automatic push_exp(input logic [7:0] bits);
        for (int i = 7; i >= 0; i--) exp_q.push_back(bits[i]);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int c;
        c = 0;
        while ((busy || dec_valid) && c < budget) begin
            tick();
            c++;
        end
        check(name, {31'd0, busy}, 32'd0);
    endtask

    // Output monitor: scoreboard on accepted beats, and hold check across stalled cycles.
    initial begin
        logic hold_prev;
        logic hold_bit;
        logic e;
        hold_prev = 1'b0;
        hold_bit  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                hold_prev = 1'b0;
            end else begin
                if (hold_prev) begin
                    check("hold_valid", {31'd0, dec_valid}, 32'd1);
                    check("hold_bit", {31'd0, dec_bit}, {31'd0, hold_bit});
                end
                if (dec_valid && dec_ready) begin
                    beats++;
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL extra_beat: got dec_bit=%0b, required no beat", dec_bit);
                    end else begin
                        e = exp_q.pop_front();
                        check("dec_bit", {31'd0, dec_bit}, {31'd0, e});
                        $display("beat %0d: dec_bit=%0b expected=%0b", beats, dec_bit, e);
                    end
                end
                hold_prev = dec_valid && !dec_ready;
                hold_bit  = dec_bit;
            end
        end
    end

    initial begin
        int         cyc;
        bit         seen;
        logic [5:0] s_e;

        vecs[0] = '{M_ZERO, 1'b0, 6'h00, 8'h00,        0, 0, 8'h00};
        vecs[1] = '{M_ONE,  1'b1, 6'h15, 8'h00,        0, 0, 8'hFF};
        vecs[2] = '{M_PATH, 1'b0, 6'h00, 8'b10110010,  0, 0, 8'b10110010};
        vecs[3] = '{M_PATH, 1'b0, 6'h00, 8'b10110010,  3, 5, 8'b10110010};
        vecs[4] = '{M_PATH, 1'b0, 6'h00, 8'b01101001,  1, 2, 8'b01101001};
        vecs[5] = '{M_ZERO, 1'b0, 6'h2A, 8'h00,        0, 3, 8'h00};
        vecs[6] = '{M_ONE,  1'b0, 6'h00, 8'h00,        5, 1, 8'hFF};

        do_reset();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_valid", {31'd0, dec_valid}, 32'd0);
        check("rst_time", {26'd0, tb_time}, 32'd0);
        check("rst_state", {26'd0, tb_state}, 32'd0);
`ifdef TB_OVERRUN_EN
        check("rst_overrun", {31'd0, overrun}, 32'd0);
`endif

        for (int v = 0; v < 7; v++) begin
            do_reset();
            s_e = vecs[v].s_end;
            case (vecs[v].mode)
                M_ZERO:  fill_const(1'b0);
                M_ONE:   fill_const(1'b1);
                default: encode_path(vecs[v].pat, s_e);
            endcase
            s_end        = s_e;
            force_state0 = vecs[v].force0;
            push_exp(vecs[v].exp_bits);
            send_cols(DEPTH);
            cyc = 0;
            while (!busy && cyc < 5) begin
                tick();
                cyc++;
            end
            check("busy_rise", {31'd0, busy}, 32'd1);
            check("start_time", {26'd0, tb_time}, 32'd47);
            check("start_state", {26'd0, tb_state}, vecs[v].force0 ? 32'd0 : {26'd0, s_e});
            cyc = 0;
            while (!dec_valid && cyc < 100) begin
                tick();
                cyc++;
                if (cyc == 7 && vecs[v].mode == M_ONE && vecs[v].force0)
                    check("state_3f", {26'd0, tb_state}, 32'h3F);
            end
            check("latency", cyc, 32'd50);
            check("wrap_time", {26'd0, tb_time}, 32'd47);
            if (vecs[v].stall_len > 0) begin
                repeat (vecs[v].stall_at) tick();
                dec_ready = 1'b0;
                repeat (vecs[v].stall_len) tick();
                dec_ready = 1'b1;
            end
            wait_idle(100, "drain");
            check("beats", beats, 32'd8);
            check("queue_empty", exp_q.size(), 32'd0);
            $display("vector %0d: expected %b, beats %0d", v, vecs[v].exp_bits, beats);
        end

        // Reset in the middle of TRACE discards the block and the column history.
        do_reset();
        fill_const(1'b0);
        send_cols(DEPTH);
        cyc = 0;
        while (!busy && cyc < 5) begin
            tick();
            cyc++;
        end
        check("t5_busy", {31'd0, busy}, 32'd1);
        repeat (21) tick();
        rst = 1'b1;
        tick();
        check("t5_busy0", {31'd0, busy}, 32'd0);
        check("t5_valid0", {31'd0, dec_valid}, 32'd0);
        check("t5_bit0", {31'd0, dec_bit}, 32'd0);
        check("t5_time0", {26'd0, tb_time}, 32'd0);
        check("t5_state0", {26'd0, tb_state}, 32'd0);
        rst = 1'b0;
        tick();
        send_cols(DEPTH - 1);
        repeat (5) tick();
        check("t5_no_start", {31'd0, busy}, 32'd0);
        push_exp(8'h00);
        send_cols(1);
        tick();
        check("t5_restart", {31'd0, busy}, 32'd1);
        wait_idle(100, "t5_drain");
        check("t5_beats", beats, 32'd8);
        $display("reset sequence: beats %0d", beats);

        // Output stalled while 16 more columns arrive: one extra block is queued, the second is lapping.
        do_reset();
        fill_const(1'b1);
        force_state0 = 1'b1;
        push_exp(8'hFF);
        dec_ready = 1'b0;
        send_cols(DEPTH);
        seen = 1'b0;
        for (int i = 0; i < 16; i++) begin
            col_valid = 1'b1;
            wp        = (wp + 1) % DEPTH;
            wr_ptr    = 6'(wp);
            tick();
            if (busy && !seen) begin
                seen = 1'b1;
                check("t6_start_time", {26'd0, tb_time}, 32'd47);
            end
        end
        col_valid = 1'b0;
        check("t6_started", {31'd0, seen}, 32'd1);
        cyc = 0;
        while (!dec_valid && cyc < 100) begin
            tick();
            cyc++;
        end
        check("t6_valid", {31'd0, dec_valid}, 32'd1);
        repeat (5) tick();
        check("t6_held", {31'd0, dec_valid}, 32'd1);
`ifdef TB_OVERRUN_EN
        check("overrun_set", {31'd0, overrun}, 32'd1);
`endif
        push_exp(8'hFF);
        dec_ready = 1'b1;
        repeat (200) tick();
        check("t6_idle", {31'd0, busy}, 32'd0);
        check("t6_beats", beats, 32'd16);
        check("t6_queue", exp_q.size(), 32'd0);
`ifdef TB_OVERRUN_EN
        check("overrun_sticky", {31'd0, overrun}, 32'd1);
`endif
        $display("overrun sequence: beats %0d", beats);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
